// File: rtl/hsyn_trim_ctrl.sv
// Horizontal-sync trim controller: tracks an external frame sync by nudging line length.
// Frame evaluation on isyn; trim/corr/state registered, hlen reloaded only on th.
module hsyn_trim_ctrl #(
  parameter int NOM_LINE = 532,
  parameter int MAX_TRIM = 8,
  parameter int LOCK_CNT = 16,
  parameter int LOST_CNT = 4,
  parameter int WDOG_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        extsyn,
  input  logic        esyn,
  input  logic        isyn,
  input  logic        uph,
  input  logic        downh,
  input  logic        beginsyn,
  input  logic        th,
  output logic [10:0] hlen,
  output logic [4:0]  trim,
  output logic        lock,
  output logic [1:0]  state,
  output logic        corr
);

  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int LSW = $clog2(LOST_CNT + 1);
  localparam int WCW = $clog2(WDOG_CNT + 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic signed [4:0]  trim_q, trim_d;
  logic [10:0]        hlen_q, hlen_d;
  logic [LCW-1:0]     clean_q, clean_d;
  logic [LSW-1:0]     lost_q, lost_d;
  logic [WCW-1:0]     wd_q, wd_d;
  logic               up_seen, up_d, dn_seen, dn_d;
  logic               corr_q, corr_d;

  logic up_ev, dn_ev, chg_req;
  assign up_ev   = up_seen | uph;
  assign dn_ev   = dn_seen | downh;
  assign chg_req = up_ev ^ dn_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      trim_q  <= '0;
      hlen_q  <= 11'(NOM_LINE);
      clean_q <= '0;
      lost_q  <= '0;
      wd_q    <= '0;
      up_seen <= 1'b0;
      dn_seen <= 1'b0;
      corr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trim_q  <= trim_d;
      hlen_q  <= hlen_d;
      clean_q <= clean_d;
      lost_q  <= lost_d;
      wd_q    <= wd_d;
      up_seen <= up_d;
      dn_seen <= dn_d;
      corr_q  <= corr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    trim_d  = trim_q;
    clean_d = clean_q;
    lost_d  = lost_q;
    wd_d    = wd_q;
    corr_d  = 1'b0;
    up_d    = isyn ? 1'b0 : up_ev;
    dn_d    = isyn ? 1'b0 : dn_ev;
    // Line length only changes at a line start, so a line is never cut mid-way.
    hlen_d  = th ? 11'(NOM_LINE + int'(trim_q)) : hlen_q;

    if (!extsyn) begin
      state_d = S_OFF;
      trim_d  = '0;
      clean_d = '0;
      lost_d  = '0;
      wd_d    = '0;
    end else if (state_q == S_OFF) begin
      state_d = S_ACQ;
    end else if (beginsyn) begin
      state_d = S_TRACK;
      trim_d  = '0;
      clean_d = '0;
      lost_d  = '0;
      wd_d    = '0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end else if (isyn && !esyn && (int'(wd_q) + 1 >= WDOG_CNT)) begin
      // External source presumed lost: fall back to acquisition from scratch.
      state_d = S_ACQ;
      trim_d  = '0;
      clean_d = '0;
      lost_d  = '0;
      wd_d    = '0;
    end else begin
      if (esyn)      wd_d = '0;
      else if (isyn) wd_d = wd_q + WCW'(1);

      if (state_q == S_ACQ) begin
        if (esyn) begin
          state_d = S_TRACK;
          clean_d = '0;
          lost_d  = '0;
        end
      end else if (isyn) begin
        if (up_ev && !dn_ev && (int'(trim_q) > -MAX_TRIM)) begin
          trim_d = trim_q - 5'sd1;
          corr_d = 1'b1;
        end else if (dn_ev && !up_ev && (int'(trim_q) < MAX_TRIM)) begin
          trim_d = trim_q + 5'sd1;
          corr_d = 1'b1;
        end

        if (state_q == S_TRACK) begin
          if (chg_req) begin
            clean_d = '0;
          end else if (int'(clean_q) + 1 >= LOCK_CNT) begin
            state_d = S_LOCK;
            clean_d = '0;
            lost_d  = '0;
          end else begin
            clean_d = clean_q + LCW'(1);
          end
        end else begin
          if (!chg_req) begin
            lost_d = '0;
          end else if (int'(lost_q) + 1 >= LOST_CNT) begin
            state_d = S_TRACK;
            lost_d  = '0;
            clean_d = '0;
          end else begin
            lost_d = lost_q + LSW'(1);
          end
        end
      end
    end
  end

  assign hlen  = hlen_q;
  assign trim  = trim_q;
  assign lock  = (state_q == S_LOCK);
  assign state = state_q;
  assign corr  = corr_q;

endmodule
